// File: rtl/mem_access_fsm_if.sv
// SRAM-like request/response channel between the MEM-stage engine and the AXI-Lite bridge.
// The master drives the request side; the slave returns addr_ok/data_ok/rdata.
interface mem_access_fsm_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req;
    logic              wr;
    logic [3:0]        sel;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       rdata;

    modport master (
        output req, wr, sel, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, sel, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_access_fsm.sv
// Multi-cycle MEM-stage load/store engine: alignment checks, big-endian lanes, bus handshake.
// Define MEM_LLSC_EN to enable LL/SC (op codes 8/9) and the internal link bit.
module mem_access_fsm #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid_i,
    input  logic [3:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       store_data_i,
    input  logic              flush_i,
    input  logic              llbit_clr_i,
    output logic              stall_o,
    output logic              result_valid_o,
    output logic [31:0]       result_data_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic [ADDR_W-1:0] bad_vaddr_o,
    mem_access_fsm_if.master  bus
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("mem_access_fsm: DATA_W must be 32");
    end

    localparam logic [3:0] OpLb  = 4'd0;
    localparam logic [3:0] OpLbu = 4'd1;
    localparam logic [3:0] OpLh  = 4'd2;
    localparam logic [3:0] OpLhu = 4'd3;
    localparam logic [3:0] OpLw  = 4'd4;
    localparam logic [3:0] OpSb  = 4'd5;
    localparam logic [3:0] OpSh  = 4'd6;
    localparam logic [3:0] OpSw  = 4'd7;
    localparam logic [3:0] OpLl  = 4'd8;
    localparam logic [3:0] OpSc  = 4'd9;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StDrain,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [3:0]        sel_q;
    logic [31:0]       wdata_q;
    logic [31:0]       res_q;
    logic              adel_q;
    logic              ades_q;

    logic        op_legal;
    logic        sc_skip;
    logic        is_byte;
    logic        is_half;
    logic        is_store;
    logic        misalign;
    logic        start;
    logic        capture;
    logic [3:0]  sel_new;
    logic [31:0] wdata_new;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;

    assign is_byte  = (op_i == OpLb) || (op_i == OpLbu) || (op_i == OpSb);
    assign is_half  = (op_i == OpLh) || (op_i == OpLhu) || (op_i == OpSh);
    assign is_store = (op_i == OpSb) || (op_i == OpSh) || (op_i == OpSw) || (op_i == OpSc);
    assign misalign = is_half ? addr_i[0] : (!is_byte && (addr_i[1:0] != 2'b00));

`ifdef MEM_LLSC_EN
    logic link_q;

    assign op_legal = (op_i <= OpSc);
    assign sc_skip  = (op_i == OpSc) && !link_q;

    // Clear wins over a same-cycle LL completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            link_q <= 1'b0;
        end else if (llbit_clr_i) begin
            link_q <= 1'b0;
        end else if (capture && (op_q == OpLl)) begin
            link_q <= 1'b1;
        end else if (capture && (op_q == OpSc)) begin
            link_q <= 1'b0;
        end
    end
`else
    logic unused_llbit_clr;

    assign op_legal         = (op_i <= OpSw);
    assign sc_skip          = 1'b0;
    assign unused_llbit_clr = llbit_clr_i;
`endif

    assign start   = (state_q == StIdle) && op_valid_i && op_legal && !flush_i;
    assign capture = (state_q == StData) && bus.data_ok && !flush_i;

    always_comb begin
        sel_new   = 4'b1111;
        wdata_new = store_data_i;
        if (is_byte) begin
            sel_new   = 4'b1000 >> addr_i[1:0];
            wdata_new = {4{store_data_i[7:0]}};
        end else if (is_half) begin
            sel_new   = addr_i[1] ? 4'b0011 : 4'b1100;
            wdata_new = {2{store_data_i[15:0]}};
        end
    end

    // Lane 3 (bits 31:24) holds byte address 00.
    always_comb begin
        byte_lane = bus.rdata[31:24];
        case (addr_q[1:0])
            2'd0:    byte_lane = bus.rdata[31:24];
            2'd1:    byte_lane = bus.rdata[23:16];
            2'd2:    byte_lane = bus.rdata[15:8];
            default: byte_lane = bus.rdata[7:0];
        endcase
        half_lane = addr_q[1] ? bus.rdata[15:0] : bus.rdata[31:16];

        load_val = bus.rdata;
        case (op_q)
            OpLb:               load_val = {{24{byte_lane[7]}}, byte_lane};
            OpLbu:              load_val = {24'h0, byte_lane};
            OpLh:               load_val = {{16{half_lane[15]}}, half_lane};
            OpLhu:              load_val = {16'h0, half_lane};
            OpSb, OpSh, OpSw:   load_val = 32'h0;
            OpSc:               load_val = 32'h1;
            default:            load_val = bus.rdata;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        stall_o        = 1'b0;
        result_valid_o = 1'b0;
        bus.req        = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    stall_o = 1'b1;
                    if (misalign || sc_skip) begin
                        state_d = StDone;
                    end else begin
                        state_d = StAddr;
                    end
                end
            end
            StAddr: begin
                stall_o = 1'b1;
                bus.req = 1'b1;
                // An accepted request must still see its data_ok, even if flushed.
                if (bus.addr_ok) begin
                    state_d = flush_i ? StDrain : StData;
                end else if (flush_i) begin
                    state_d = StIdle;
                end
            end
            StData: begin
                stall_o = 1'b1;
                if (bus.data_ok) begin
                    state_d = flush_i ? StIdle : StDone;
                end else if (flush_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (bus.data_ok) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                result_valid_o = !flush_i;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= 4'h0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            sel_q   <= 4'h0;
            wdata_q <= 32'h0;
            res_q   <= 32'h0;
            adel_q  <= 1'b0;
            ades_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                op_q    <= op_i;
                addr_q  <= addr_i;
                wr_q    <= is_store;
                sel_q   <= sel_new;
                wdata_q <= wdata_new;
                res_q   <= 32'h0;
                adel_q  <= misalign && !is_store;
                ades_q  <= misalign && is_store;
            end else if (capture) begin
                res_q <= load_val;
            end
        end
    end

    assign bus.wr    = wr_q;
    assign bus.sel   = sel_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;

    assign result_data_o = result_valid_o ? res_q : 32'h0;
    assign adel_o        = result_valid_o && adel_q;
    assign ades_o        = result_valid_o && ades_q;
    assign bad_vaddr_o   = (result_valid_o && (adel_q || ades_q)) ? addr_q : '0;

endmodule
